change_dispenser: RTL and testbench

- Payout end of the coin path. The item FSMs count coins in; this block pays coins out.
- It accepts a change or refund amount in cents through a valid/ready handshake.
- It drives one-cycle eject pulses to the dime and nickel hoppers, greedy dimes first, with a programmable cooldown between coins.
- It keeps a per-denomination coin inventory: incremented by collected coins, decremented by ejects. On completion it reports any unpaid shortfall.

---
 rtl/change_dispenser.sv | 133 +++++++++++++
 tb/tb_change_dispenser.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Coin payout engine: takes a change amount, ejects dimes then nickels with a
// cooldown between coins, and tracks per-denomination hopper inventory.
module change_dispenser #(
    parameter int AMT_W       = 8,
    parameter int CNT_W       = 8,
    parameter int NICKEL_INIT = 20,
    parameter int DIME_INIT   = 20,
    parameter int GAP_CYCLES  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             coin_in_nickel,
    input  logic             coin_in_dime,
    output logic             nickel_out,
    output logic             dime_out,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] short_amount,
    output logic [CNT_W-1:0] nickel_count,
    output logic [CNT_W-1:0] dime_count
);

    typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, DONE} state_t;

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]    GAP_LOAD = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    localparam logic [AMT_W-1:0] TEN      = AMT_W'(10);
    localparam logic [AMT_W-1:0] FIVE     = AMT_W'(5);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [AMT_W-1:0] short_q, short_d;
    logic [CNT_W-1:0] nick_q, nick_d, dime_q, dime_d;
    logic             nout_q, dout_q, done_q, ready_q, busy_q;
    logic             nej, dej, done_d;

    // Saturating add, plain decrement; a same-type add and eject cancel out.
    function automatic logic [CNT_W-1:0] inv_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
        if (inc && !dec)      return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        else if (dec && !inc) return cnt - 1'b1;
        else                  return cnt;
    endfunction

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        short_d = short_q;
        nej     = 1'b0;
        dej     = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                rem_d   = req_amount;
                state_d = SELECT;
            end
            SELECT: begin
                if (rem_q >= TEN && dime_q != '0) begin
                    dej     = 1'b1;
                    rem_d   = rem_q - TEN;
                    state_d = EJECT;
                end else if (rem_q >= FIVE && nick_q != '0) begin
                    nej     = 1'b1;
                    rem_d   = rem_q - FIVE;
                    state_d = EJECT;
                end else begin
                    done_d  = 1'b1;
                    short_d = rem_q;
                    state_d = DONE;
                end
            end
            EJECT: begin
                if (GAP_CYCLES == 0) state_d = SELECT;
                else begin
                    state_d = GAP;
                    gap_d   = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_q == '0) state_d = SELECT;
                else             gap_d   = gap_q - 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        nick_d = inv_next(nick_q, coin_in_nickel, nej);
        dime_d = inv_next(dime_q, coin_in_dime, dej);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            gap_q   <= '0;
            short_q <= '0;
            nick_q  <= CNT_W'(NICKEL_INIT);
            dime_q  <= CNT_W'(DIME_INIT);
            nout_q  <= 1'b0;
            dout_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            short_q <= short_d;
            nick_q  <= nick_d;
            dime_q  <= dime_d;
            nout_q  <= nej;
            dout_q  <= dej;
            done_q  <= done_d;
            ready_q <= (state_d == IDLE);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign req_ready    = ready_q;
    assign busy         = busy_q;
    assign nickel_out   = nout_q;
    assign dime_out     = dout_q;
    assign done         = done_q;
    assign short_amount = short_q;
    assign nickel_count = nick_q;
    assign dime_count   = dime_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed literal scenarios plus a random run,
// all checked every cycle against a schedule-based payout model.
module tb_change_dispenser;

    localparam int AW = 8, CW = 4, NI = 4, DI = 2, G = 2;
    localparam int P = G + 2;           // cycles between successive coins
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0, reset = 1'b1;
    logic          req_valid = 1'b0, coin_in_nickel = 1'b0, coin_in_dime = 1'b0;
    logic [AW-1:0] req_amount = '0;
    logic          req_ready, nickel_out, dime_out, busy, done;
    logic [AW-1:0] short_amount;
    logic [CW-1:0] nickel_count, dime_count;

    change_dispenser #(.AMT_W(AW), .CNT_W(CW), .NICKEL_INIT(NI), .DIME_INIT(DI),
                       .GAP_CYCLES(G)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_amount(req_amount),
        .req_ready(req_ready), .coin_in_nickel(coin_in_nickel), .coin_in_dime(coin_in_dime),
        .nickel_out(nickel_out), .dime_out(dime_out), .busy(busy), .done(done),
        .short_amount(short_amount), .nickel_count(nickel_count), .dime_count(dime_count));

    always #5 clock = ~clock;

    int checks = 0, errors = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a request accepted at edge 0 makes a greedy coin decision at edges
    // 1, 1+P, 1+2P ...; each decision is visible the cycle after that edge.
    int   m_e, m_k, m_rem, m_nick, m_dime, x_short;
    logic m_active, m_fin, x_n, x_d, x_done;

    always @(posedge clock or posedge reset) begin : model
        int   nrem, ns, nn, nd;
        logic en, ed, edn;
        if (reset) begin
            m_active <= 1'b0; m_fin <= 1'b0; m_e <= 0; m_k <= 0; m_rem <= 0;
            m_nick <= NI; m_dime <= DI;
            x_n <= 1'b0; x_d <= 1'b0; x_done <= 1'b0; x_short <= 0;
        end else begin
            en = 1'b0; ed = 1'b0; edn = 1'b0; nrem = m_rem; ns = x_short;
            if (!m_active) begin
                if (req_valid) begin
                    m_active <= 1'b1; m_fin <= 1'b0; m_e <= 1; m_k <= 0;
                    nrem = int'(req_amount);
                end
            end else if (m_fin) begin
                m_active <= 1'b0;
            end else begin
                if (m_e == 1 + m_k * P) begin
                    if (m_rem >= 10 && m_dime > 0) begin
                        ed = 1'b1; nrem = m_rem - 10; m_k <= m_k + 1;
                    end else if (m_rem >= 5 && m_nick > 0) begin
                        en = 1'b1; nrem = m_rem - 5; m_k <= m_k + 1;
                    end else begin
                        edn = 1'b1; ns = m_rem; m_fin <= 1'b1;
                    end
                end
                m_e <= m_e + 1;
            end
            nn = m_nick + int'(coin_in_nickel) - int'(en);
            nd = m_dime + int'(coin_in_dime) - int'(ed);
            m_nick <= (nn > CMAX) ? CMAX : nn;
            m_dime <= (nd > CMAX) ? CMAX : nd;
            m_rem <= nrem; x_n <= en; x_d <= ed; x_done <= edn; x_short <= ns;
        end
    end

    always @(negedge clock) begin
        if (chk_en && !reset) begin
            chk("req_ready", req_ready, !m_active);
            chk("busy", busy, m_active);
            chk("nickel_out", nickel_out, x_n);
            chk("dime_out", dime_out, x_d);
            chk("done", done, x_done);
            chk("short_amount", short_amount, x_short);
            chk("nickel_count", nickel_count, m_nick);
            chk("dime_count", dime_count, m_dime);
            chk("one_pulse", nickel_out & dime_out, 0);
        end
    end

    function automatic logic [63:0] b(input int i);
        b = 64'd1 << i;
    endfunction

    logic [63:0] pn, pd, pdone, pr;
    int          last_short, dcnt2;

    // Request amt when idle; record outputs for cycles 1..ncyc after the handshake.
    task automatic do_req(input int amt, input int ncyc, input int rel, input int dime_at);
        int w = 0;
        @(negedge clock);
        while (!req_ready && w < 200) begin @(negedge clock); w++; end
        if (w >= 200) chk("ready_timeout", 0, 1);
        req_valid = 1'b1; req_amount = AW'(amt);
        @(posedge clock);
        pn = '0; pd = '0; pdone = '0; pr = '0; last_short = -1; dcnt2 = -1;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clock);
            if (n == rel) req_valid = 1'b0;
            coin_in_dime = (n == dime_at);
            pn[n] = nickel_out; pd[n] = dime_out; pdone[n] = done; pr[n] = req_ready;
            if (done) last_short = int'(short_amount);
            if (n == 2) dcnt2 = int'(dime_count);
        end
        coin_in_dime = 1'b0;
    endtask

    task automatic coin(input logic n, input logic d, input int times);
        for (int i = 0; i < times; i++) begin
            @(negedge clock); coin_in_nickel = n; coin_in_dime = d;
            @(negedge clock); coin_in_nickel = 1'b0; coin_in_dime = 1'b0;
        end
    endtask

    initial begin
        #12;
        chk("rst_ready", req_ready, 1); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0); chk("rst_short", short_amount, 0);
        chk("rst_pulses", {nickel_out, dime_out}, 0);
        chk("rst_ncnt", nickel_count, NI); chk("rst_dcnt", dime_count, DI);
        @(negedge clock); reset = 1'b0; chk_en = 1'b1;

        // Greedy pay of 35 with 2 dimes / 4 nickels on hand.
        do_req(35, 23, 1, 0);
        chk("t1_dimes", pd, b(2) | b(6));
        chk("t1_nickels", pn, b(10) | b(14) | b(18));
        chk("t1_done", pdone, b(22));
        chk("t1_short", last_short, 0);
        chk("t1_ready", pr, b(23));
        chk("t1_dcnt", dime_count, 0); chk("t1_ncnt", nickel_count, 1);

        // Shortfall: 20 requested, only one nickel left.
        do_req(20, 7, 1, 0);
        chk("t2_nickels", pn, b(2)); chk("t2_dimes", pd, 0);
        chk("t2_done", pdone, b(6)); chk("t2_short", last_short, 15);
        chk("t2_ncnt", nickel_count, 0);

        // Zero amount.
        do_req(0, 3, 1, 0);
        chk("t3_pulses", pn | pd, 0); chk("t3_done", pdone, b(2));
        chk("t3_short", last_short, 0); chk("t3_ready", pr, b(3));

        // Residue: 7 cents with one nickel.
        coin(1'b1, 1'b0, 1);
        do_req(7, 7, 1, 0);
        chk("t4_nickels", pn, b(2)); chk("t4_done", pdone, b(6));
        chk("t4_short", last_short, 2);

        // Collision on the eject edge, with req_valid held through the first request.
        coin(1'b0, 1'b1, 2);
        do_req(10, 14, 8, 1);
        chk("t5_dcnt_collide", dcnt2, 2);
        chk("t5_dimes", pd, b(2) | b(9));
        chk("t5_done", pdone, b(6) | b(13));
        chk("t5_ready", pr, b(7) | b(14));
        chk("t5_dcnt", dime_count, 1);

        // Saturation of the 4-bit nickel counter.
        coin(1'b1, 1'b0, 20);
        @(negedge clock);
        chk("sat_ncnt", nickel_count, CMAX);

        // Asynchronous reset while a dime pulse is high.
        @(negedge clock); req_valid = 1'b1; req_amount = AW'(30);
        @(posedge clock); @(negedge clock); req_valid = 1'b0;
        @(posedge clock); #1;
        chk("rm_pulse_before", dime_out, 1);
        #1 reset = 1'b1; #1;
        chk("rm_pulse_drop", dime_out, 0); chk("rm_busy", busy, 0);
        chk("rm_ready", req_ready, 1); chk("rm_done", done, 0);
        chk("rm_ncnt", nickel_count, NI); chk("rm_dcnt", dime_count, DI);
        @(negedge clock); #2 reset = 1'b0;

        // Random traffic with occasional coin inserts and asynchronous resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            req_valid      = ($urandom_range(0, 2) == 0);
            req_amount     = AW'($urandom_range(0, 60));
            coin_in_nickel = ($urandom_range(0, 5) == 0);
            coin_in_dime   = ($urandom_range(0, 5) == 0);
            if (reset) #2 reset = 1'b0;
            else if ($urandom_range(0, 599) == 0) #2 reset = 1'b1;
        end
        @(negedge clock);
        req_valid = 1'b0; coin_in_nickel = 1'b0; coin_in_dime = 1'b0;
        if (reset) #2 reset = 1'b0;
        repeat (5) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
